// File: rtl/branch_hazard_unit.sv
// Decode-stage branch hazard unit for early branch resolution.
//
// Compares the ID-stage branch sources against the destinations in ID/EX, EX/MEM
// and MEM/WB. It selects the forwarding source for each branch operand, stalls on
// load-use hazards and flushes IF/ID on a taken branch. It also keeps saturating
// branch statistics.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_branch           ID holds a conditional branch
//   id_uses_rs2         branch compares rs1 against rs2 (else against zero)
//   id_rs1, id_rs2      branch source registers
//   idex_*, exmem_*     destination info of the instructions in EX and MEM
//   memwb_*             destination info of the instruction in WB
//   branch_taken        comparator result on the forwarded operands
//   cnt_clr             synchronous clear of the statistics counters
//   forward_c           [1:0] rs1 select, [3:2] rs2 select
//                       00 = regfile, 01 = EX ALU, 10 = EX/MEM ALU, 11 = WB data
//   stall               freeze PC and IF/ID, bubble into ID/EX
//   flush_ifid          squash IF/ID on a taken branch
//   branch_cnt          resolved branches
//   taken_cnt           taken branches
//   stall_cnt           branch stall cycles
module branch_hazard_unit #(
  parameter int unsigned REG_AW   = 3,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_branch,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              idex_regwrite,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              exmem_regwrite,
  input  logic              exmem_memread,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              branch_taken,
  input  logic              cnt_clr,
  output logic [3:0]        forward_c,
  output logic              stall,
  output logic              flush_ifid,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // WAIT2 is reserved and never entered; if it is ever seen it drains like WAIT1.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StWait2 = 2'b01,
    StWait1 = 2'b10
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] branch_cnt_q, taken_cnt_q, stall_cnt_q;

  // Per-operand decode. Returns {h2, h1, sel[1:0]}. A hazard operand reports
  // sel=00; the nearest matching stage always wins.
  function automatic logic [3:0] decode_op(
    input logic [REG_AW-1:0] src,
    input logic              en,
    input logic              ex_wr,
    input logic              ex_ld,
    input logic [REG_AW-1:0] ex_rd,
    input logic              mem_wr,
    input logic              mem_ld,
    input logic [REG_AW-1:0] mem_rd,
    input logic              wb_wr,
    input logic [REG_AW-1:0] wb_rd
  );
    logic live;
    logic [3:0] res;
    res  = 4'b0000;
    live = en && !(ZERO_REG && (src == '0));
    if (live && ex_wr && (ex_rd == src)) begin
      res = ex_ld ? 4'b1000 : 4'b0001;
    end else if (live && mem_wr && (mem_rd == src)) begin
      res = mem_ld ? 4'b0100 : 4'b0010;
    end else if (live && wb_wr && (wb_rd == src)) begin
      res = 4'b0011;
    end
    return res;
  endfunction

  logic [3:0] dec_rs1, dec_rs2;
  logic       any_h2, any_h1;

  always_comb begin
    dec_rs1 = decode_op(id_rs1, 1'b1, idex_regwrite, idex_memread, idex_rd,
                        exmem_regwrite, exmem_memread, exmem_rd, memwb_regwrite, memwb_rd);
    dec_rs2 = decode_op(id_rs2, id_uses_rs2, idex_regwrite, idex_memread, idex_rd,
                        exmem_regwrite, exmem_memread, exmem_rd, memwb_regwrite, memwb_rd);
    any_h2  = dec_rs1[3] | dec_rs2[3];
    any_h1  = dec_rs1[2] | dec_rs2[2];
  end

  // Next state and outputs.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    forward_c = 4'b0000;
    case (state_q)
      StIdle: begin
        if (id_branch) begin
          forward_c = {dec_rs2[1:0], dec_rs1[1:0]};
          if (any_h2) begin
            // Load in EX: stall now and once more in WAIT1.
            stall   = 1'b1;
            state_d = StWait1;
          end else if (any_h1) begin
            // Load in MEM: one stall, then re-evaluate with the load in WB.
            stall = 1'b1;
          end
        end
      end
      default: begin
        stall   = 1'b1;
        state_d = StIdle;
      end
    endcase
    // Reset cycle shows a quiet interface.
    if (rst) begin
      state_d   = StIdle;
      stall     = 1'b0;
      forward_c = 4'b0000;
    end
  end

  assign flush_ifid = id_branch & branch_taken & ~stall & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Saturating statistics; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (id_branch && !stall && (branch_cnt_q != '1)) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
      if (flush_ifid && (taken_cnt_q != '1)) begin
        taken_cnt_q <= taken_cnt_q + CNT_W'(1);
      end
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Testbench for branch_hazard_unit: two instances share the stimulus, one with the
// default parameters and one with ZERO_REG=0 and 4-bit counters (to reach saturation).
module tb_branch_hazard_unit;

  logic       clk = 1'b0;
  logic       rst, id_branch, id_uses_rs2, branch_taken, cnt_clr;
  logic [2:0] id_rs1, id_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       idex_regwrite, idex_memread, exmem_regwrite, exmem_memread, memwb_regwrite;

  logic [3:0]  fc0, fc1;
  logic        stall0, stall1, flush0, flush1;
  logic [15:0] bc0, tc0, sc0;
  logic [3:0]  bc1, tc1, sc1;

  always #5 clk = ~clk;

  branch_hazard_unit #(.REG_AW(3), .ZERO_REG(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_branch(id_branch), .id_uses_rs2(id_uses_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .idex_regwrite(idex_regwrite),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .exmem_regwrite(exmem_regwrite),
    .exmem_memread(exmem_memread), .exmem_rd(exmem_rd), .memwb_regwrite(memwb_regwrite),
    .memwb_rd(memwb_rd), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
    .forward_c(fc0), .stall(stall0), .flush_ifid(flush0),
    .branch_cnt(bc0), .taken_cnt(tc0), .stall_cnt(sc0)
  );

  branch_hazard_unit #(.REG_AW(3), .ZERO_REG(1'b0), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_branch(id_branch), .id_uses_rs2(id_uses_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .idex_regwrite(idex_regwrite),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .exmem_regwrite(exmem_regwrite),
    .exmem_memread(exmem_memread), .exmem_rd(exmem_rd), .memwb_regwrite(memwb_regwrite),
    .memwb_rd(memwb_rd), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
    .forward_c(fc1), .stall(stall1), .flush_ifid(flush1),
    .branch_cnt(bc1), .taken_cnt(tc1), .stall_cnt(sc1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: per instance, remaining forced stall cycles and plain counts.
  int  stall_left[2];
  int  bcnt[2], tcnt[2], scnt[2];
  int  cmax[2] = '{65535, 15};
  bit  zr[2]   = '{1'b1, 1'b0};
  bit  known   = 1'b0;
  int  n_left[2], n_b[2], n_t[2], n_s[2];

  // sel: 0..3 select; haz: 0 none, 1 load in MEM, 2 load in EX.
  function automatic void op_sel(input int src, input bit en, input bit z,
                                 output int sel, output int haz);
    bit live;
    sel  = 0;
    haz  = 0;
    live = en && !(z && src == 0);
    if (!live) return;
    if (idex_regwrite && int'(idex_rd) == src) begin
      if (idex_memread) haz = 2; else sel = 1;
    end else if (exmem_regwrite && int'(exmem_rd) == src) begin
      if (exmem_memread) haz = 1; else sel = 2;
    end else if (memwb_regwrite && int'(memwb_rd) == src) begin
      sel = 3;
    end
  endfunction

  function automatic int sat_inc(input int v, input bit inc, input int mx);
    return (inc && v < mx) ? v + 1 : v;
  endfunction

  // Compares both instances against the model shortly after inputs change,
  // then computes the model's next state.
  task automatic sample_check();
    int e_fc, e_stall, e_flush, s1, h1, s2, h2, worst;
    int a_fc, a_stall, a_flush, a_b, a_t, a_s;
    bit hz_idle;
    string p;
    #1;
    for (int k = 0; k < 2; k++) begin
      e_fc = 0; e_stall = 0; hz_idle = 1'b0; n_left[k] = 0;
      if (rst) begin
        e_stall = 0;
      end else if (stall_left[k] > 0) begin
        e_stall   = 1;
        n_left[k] = stall_left[k] - 1;
      end else if (id_branch) begin
        op_sel(int'(id_rs1), 1'b1, zr[k], s1, h1);
        op_sel(int'(id_rs2), id_uses_rs2, zr[k], s2, h2);
        worst = (h1 > h2) ? h1 : h2;
        e_fc  = s2 * 4 + s1;
        if (worst > 0) begin
          e_stall = 1;
          hz_idle = 1'b1;
          if (worst == 2) n_left[k] = 1;
        end
      end
      e_flush = (!rst && id_branch && branch_taken && e_stall == 0) ? 1 : 0;

      if (k == 0) begin
        p = "m"; a_fc = fc0; a_stall = stall0; a_flush = flush0;
        a_b = bc0; a_t = tc0; a_s = sc0;
      end else begin
        p = "s"; a_fc = fc1; a_stall = stall1; a_flush = flush1;
        a_b = bc1; a_t = tc1; a_s = sc1;
      end
      // A hazard operand's select is not meaningful while stalling in IDLE.
      if (!hz_idle) check_val({p, "_fc"}, a_fc, e_fc);
      check_val({p, "_stall"}, a_stall, e_stall);
      check_val({p, "_flush"}, a_flush, e_flush);
      if (known) begin
        check_val({p, "_bcnt"}, a_b, bcnt[k]);
        check_val({p, "_tcnt"}, a_t, tcnt[k]);
        check_val({p, "_scnt"}, a_s, scnt[k]);
      end

      if (rst || cnt_clr) begin
        n_b[k] = 0; n_t[k] = 0; n_s[k] = 0;
      end else begin
        n_b[k] = sat_inc(bcnt[k], id_branch && e_stall == 0, cmax[k]);
        n_t[k] = sat_inc(tcnt[k], e_flush == 1, cmax[k]);
        n_s[k] = sat_inc(scnt[k], e_stall == 1, cmax[k]);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) known = 1'b1;
    for (int k = 0; k < 2; k++) begin
      stall_left[k] = n_left[k];
      bcnt[k] = n_b[k]; tcnt[k] = n_t[k]; scnt[k] = n_s[k];
    end
    @(negedge clk);
  endtask

  task automatic step();
    sample_check();
    advance();
  endtask

  task automatic quiet();
    rst = 0; id_branch = 0; id_uses_rs2 = 0; branch_taken = 0; cnt_clr = 0;
    id_rs1 = 0; id_rs2 = 0; idex_rd = 0; exmem_rd = 0; memwb_rd = 0;
    idex_regwrite = 0; idex_memread = 0; exmem_regwrite = 0; exmem_memread = 0;
    memwb_regwrite = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      stall_left[k] = 0; bcnt[k] = 0; tcnt[k] = 0; scnt[k] = 0;
    end
    quiet();
    @(negedge clk);
    do_reset();
    // Reset state
    quiet(); sample_check();
    check_val("rst_stall", stall0, 0);
    check_val("rst_bcnt", bc0, 0);
    advance();

    // Select encoding: EX ALU for rs1, WB for rs2
    quiet(); id_branch = 1; id_uses_rs2 = 1; id_rs1 = 3; id_rs2 = 5;
    idex_regwrite = 1; idex_rd = 3; memwb_regwrite = 1; memwb_rd = 5;
    sample_check();
    check_val("sel_enc", fc0, 4'b1101);
    advance();

    // Priority: EX/MEM beats MEM/WB; r0 never matches with ZERO_REG=1
    quiet(); id_branch = 1; id_rs1 = 2;
    exmem_regwrite = 1; exmem_rd = 2; memwb_regwrite = 1; memwb_rd = 2;
    sample_check();
    check_val("prio_r2", fc0[1:0], 2'b10);
    advance();
    id_rs1 = 0; exmem_rd = 0; memwb_rd = 0;
    sample_check();
    check_val("prio_r0", fc0[1:0], 2'b00);
    check_val("prio_r0_nz", fc1[1:0], 2'b10);
    advance();

    // Load-use with the load in EX: two stall cycles, then WB forward
    do_reset();
    quiet(); id_branch = 1; id_rs1 = 4; idex_regwrite = 1; idex_memread = 1; idex_rd = 4;
    sample_check(); check_val("ldex_st1", stall0, 1); advance();
    quiet(); id_branch = 1; id_rs1 = 4; exmem_regwrite = 1; exmem_memread = 1; exmem_rd = 4;
    sample_check(); check_val("ldex_st2", stall0, 1); advance();
    quiet(); id_branch = 1; id_rs1 = 4; memwb_regwrite = 1; memwb_rd = 4;
    sample_check();
    check_val("ldex_fwd", fc0[1:0], 2'b11);
    check_val("ldex_st3", stall0, 0);
    check_val("ldex_scnt", sc0, 2);
    advance();

    // Load in MEM on rs2: one stall, then WB forward; ignored when rs2 unused
    quiet(); id_branch = 1; id_uses_rs2 = 1; id_rs1 = 1; id_rs2 = 6;
    exmem_regwrite = 1; exmem_memread = 1; exmem_rd = 6;
    sample_check(); check_val("ldmem_st", stall0, 1); advance();
    quiet(); id_branch = 1; id_uses_rs2 = 1; id_rs1 = 1; id_rs2 = 6;
    memwb_regwrite = 1; memwb_rd = 6;
    sample_check(); check_val("ldmem_fwd", fc0[3:2], 2'b11); advance();
    quiet(); id_branch = 1; id_uses_rs2 = 0; id_rs2 = 6;
    exmem_regwrite = 1; exmem_memread = 1; exmem_rd = 6;
    sample_check(); check_val("nors2_st", stall0, 0); advance();

    // Flush and counters
    do_reset();
    quiet(); id_branch = 1; branch_taken = 1; id_rs1 = 1;
    sample_check(); check_val("flush", flush0, 1); advance();
    quiet();
    sample_check();
    check_val("flush_bcnt", bc0, 1);
    check_val("flush_tcnt", tc0, 1);
    advance();
    quiet(); id_branch = 1; branch_taken = 1; id_rs1 = 1;
    idex_regwrite = 1; idex_memread = 1; idex_rd = 1;
    sample_check(); check_val("noflush_st", flush0, 0); advance();
    quiet(); step();
    for (int i = 0; i < 20; i++) begin
      quiet(); id_branch = 1; branch_taken = 1; step();
    end
    quiet(); sample_check();
    check_val("sat_bcnt", bc1, 15);
    check_val("sat_tcnt", tc1, 15);
    advance();
    quiet(); id_branch = 1; branch_taken = 1; cnt_clr = 1; step();
    quiet(); sample_check();
    check_val("clr_bcnt", bc0, 0);
    check_val("clr_tcnt", tc1, 0);
    advance();

    // Reset during WAIT1
    quiet(); id_branch = 1; id_rs1 = 5; idex_regwrite = 1; idex_memread = 1; idex_rd = 5;
    step();
    quiet(); rst = 1;
    sample_check(); check_val("rstw_stall", stall0, 0); advance();
    quiet(); sample_check();
    check_val("rstw_idle", stall0, 0);
    check_val("rstw_scnt", sc0, 0);
    advance();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 63) == 0);
      cnt_clr        = ($urandom_range(0, 31) == 0);
      id_branch      = ($urandom_range(0, 3) != 0);
      id_uses_rs2    = $urandom_range(0, 1);
      branch_taken   = $urandom_range(0, 1);
      id_rs1         = 3'($urandom_range(0, 7));
      id_rs2         = 3'($urandom_range(0, 7));
      idex_regwrite  = $urandom_range(0, 1);
      idex_memread   = ($urandom_range(0, 2) == 0);
      idex_rd        = 3'($urandom_range(0, 7));
      exmem_regwrite = $urandom_range(0, 1);
      exmem_memread  = ($urandom_range(0, 2) == 0);
      exmem_rd       = 3'($urandom_range(0, 7));
      memwb_regwrite = $urandom_range(0, 1);
      memwb_rd       = 3'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_hazard_unit.md
Name: branch_hazard_unit

Overview:
- Decode-stage control block for early branch resolution in the 16-bit pipeline.
- Compares the branch source registers in ID against the destinations held in ID/EX, EX/MEM and MEM/WB.
- Produces the 4-bit forward_c select that drives the ID-stage branch operand muxes. Encoding per operand: 00 = register file, 01 = live EX ALU result, 10 = EX/MEM ALU result, 11 = WB data.
- Owns the load-use stall FSM, the taken-branch IF/ID flush, and saturating branch statistics counters.

Parameters:
REG_AW, 3, register address width
ZERO_REG, 1, when 1 register 0 is hardwired zero and never matches for forwarding or hazards
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
id_branch  input  1  instruction in ID is a conditional branch
id_uses_rs2  input  1  branch compares rs1 against rs2; 0 means compare rs1 against zero
id_rs1  input  REG_AW  branch source 1
id_rs2  input  REG_AW  branch source 2
idex_regwrite  input  1  ID/EX instruction writes a register
idex_memread  input  1  ID/EX instruction is a load
idex_rd  input  REG_AW  ID/EX destination
exmem_regwrite  input  1  EX/MEM instruction writes a register
exmem_memread  input  1  EX/MEM instruction is a load
exmem_rd  input  REG_AW  EX/MEM destination
memwb_regwrite  input  1  MEM/WB instruction writes a register
memwb_rd  input  REG_AW  MEM/WB destination
branch_taken  input  1  comparator result on the forwarded operands, same cycle
cnt_clr  input  1  synchronous clear of all counters
forward_c  output  4  [1:0] select for rs1, [3:2] select for rs2
stall  output  1  freeze PC and IF/ID, insert bubble into ID/EX
flush_ifid  output  1  squash IF/ID on a taken branch
branch_cnt  output  CNT_W  resolved branches
taken_cnt  output  CNT_W  taken branches
stall_cnt  output  CNT_W  branch stall cycles

Behaviour:
- Match rule for each operand: the stage writes, rd equals the source, and the source is nonzero when ZERO_REG=1.
- rs2 is considered only when id_uses_rs2=1. Otherwise the rs2 select is 00 and rs2 raises no hazard.
- Select priority per operand, evaluated only when id_branch=1 and state=IDLE (otherwise forward_c=0000):
  - ID/EX match, non-load: 01.
  - ID/EX match, load: hazard H2.
  - Else EX/MEM match, non-load: 10.
  - Else EX/MEM match, load: hazard H1.
  - Else MEM/WB match: 11.
  - Else: 00.
- A nearer stage always wins. Example: an ID/EX match blocks a MEM/WB match on the same register.
- FSM states: IDLE, WAIT2, WAIT1. Reset state is IDLE.
  - IDLE, any operand with H2: stall=1 this cycle; next state WAIT1.
  - IDLE, H1 and no H2: stall=1 this cycle; next state IDLE (re-evaluate next cycle).
  - IDLE, no hazard: stall=0.
  - WAIT1: stall=1, forward_c=0000; next state IDLE.
  - WAIT2 is reserved: it behaves as WAIT1 and leads to IDLE; the unit never enters it.
  - Net effect: a load in EX costs 2 stall cycles and a load in MEM costs 1. Afterwards the loaded value arrives via 11.
- stall is combinational from the state and the hazard detection. stall is 0 whenever id_branch=0 in IDLE.
- flush_ifid = id_branch & branch_taken & ~stall, combinational.
- Counters, registered, each saturating at all-ones (no wrap):
  - branch_cnt +1 when id_branch & ~stall.
  - taken_cnt +1 when flush_ifid.
  - stall_cnt +1 every cycle stall=1.
- cnt_clr has priority over increments. An increment in the same cycle as cnt_clr is dropped.
- rst forces state=IDLE and all counters to 0, including mid-WAIT1. The reset-cycle outputs are forward_c=0000, stall=0, flush_ifid=0. The stall sequence does not resume after reset.
- Simultaneous hazards on rs1 and rs2: H2 dominates. Example: rs1 has H2 and rs2 has H1 gives the H2 sequence.

Test Plan:
- Select encoding: id_branch=1, rs1=3, rs2=5, ID/EX writes r3 (non-load), MEM/WB writes r5 -> forward_c=1101, stall=0.
- Priority: EX/MEM and MEM/WB both write r2, rs1=2 -> forward_c[1:0]=10. Repeat with r0 and ZERO_REG=1 -> 00.
- Load-use in EX: ID/EX load r4, rs1=4 -> stall 1,1 over two cycles. Third cycle, with the load now in MEM/WB -> forward_c[1:0]=11, stall=0. stall_cnt=2.
- Load in MEM: EX/MEM load r6, rs2=6, id_uses_rs2=1 -> one stall cycle, then forward_c[3:2]=11. With id_uses_rs2=0 -> no stall.
- Flush and counters: unstalled branch with branch_taken=1 -> flush_ifid=1, branch_cnt=1, taken_cnt=1. Same branch while stalled -> flush_ifid=0. Preload counters to 0xFFFF -> they hold at 0xFFFF. cnt_clr together with an increment -> 0.
- Reset mid-stall: assert rst during WAIT1 -> next cycle state=IDLE, stall=0, all counters 0.
